dda_param_loader: RTL

// Writer side of the dda configuration interface: drives icx, icy, mu, dt, en and rst of the dda core.

---
 rtl/dda_param_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dda_param_loader.sv
// dda_param_loader: byte-stream writer for the dda core configuration.
// Assembles posit words (icx/icy/mu/dt) and the step divider from a
// valid/ready byte port and sequences the core through IDLE/INIT/RUN.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   data_in[7:0]     command/data byte
//   data_valid       data_in valid this cycle
//   data_ready       byte accepted this cycle (low only in INIT)
//   icx, icy         initial conditions (posit, N bits)
//   mu, dt           Van der Pol parameter and Euler step (posit, N bits)
//   dda_en, dda_rst  core enable / core reset
//   running          high while in RUN
module dda_param_loader #(
    parameter int N     = 16,
    parameter int ES    = 1,
    parameter int DIV_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic [N-1:0] mu,
    output logic [N-1:0] dt,
    output logic         dda_en,
    output logic         dda_rst,
    output logic         running
);

    localparam int NB   = N / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0] LAST_B = BC_W'(NB - 1);

    // 1.0 is sign 0, regime "10", rest zero.
    localparam logic [N-1:0] MU_RST = N'(1) << (N - 2);

    // 1/16 = useed^-k * 2^e with useed = 2^(2^ES): regime of K_ABS zeros
    // then a one, followed by the ES-bit exponent.
    localparam int K_ABS  = (4 + (1 << ES) - 1) >> ES;
    localparam int E_DT   = (K_ABS << ES) - 4;
    localparam int DT_ONE = N - 2 - K_ABS;
    localparam logic [N-1:0] DT_RST =
        (N'(1) << DT_ONE) | (N'(E_DT) << (DT_ONE - ES));

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN
    } fsm_t;

    typedef enum logic [1:0] {
        P_CMD,
        P_WORD,
        P_DIV
    } parse_t;

    fsm_t             state, state_next;
    parse_t           pstate;
    logic [BC_W-1:0]  bcnt;
    logic [1:0]       addr;
    logic [N-1:0]     shreg;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    logic             acc;
    logic             cmd_start;
    logic             cmd_stop;
    logic             div_wr;
    logic [N+7:0]     word_cat;
    logic [N-1:0]     word_next;
    logic [DIV_W+7:0] div_ext;
    logic [DIV_W-1:0] div_new;

    assign data_ready = (state != S_INIT);
    assign acc        = data_valid & data_ready;
    assign cmd_start  = acc && (pstate == P_CMD) && (data_in[7:6] == 2'b01);
    assign cmd_stop   = acc && (pstate == P_CMD) && (data_in[7:6] == 2'b10);
    assign div_wr     = acc && (pstate == P_DIV);

    // Shift a byte in MSB first; works down to N = 8.
    assign word_cat   = {shreg, data_in};
    assign word_next  = word_cat[N-1:0];
    assign div_ext    = {{DIV_W{1'b0}}, data_in};
    assign div_new    = div_ext[DIV_W-1:0];

    // Byte parser and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate <= P_CMD;
            bcnt   <= '0;
            addr   <= '0;
            shreg  <= '0;
            icx    <= '0;
            icy    <= '0;
            mu     <= MU_RST;
            dt     <= DT_RST;
            div    <= '0;
        end else if (acc) begin
            unique case (pstate)
                P_CMD: begin
                    if (data_in[7:6] == 2'b00) begin
                        pstate <= P_WORD;
                        addr   <= data_in[1:0];
                        bcnt   <= '0;
                    end else if (data_in[7:6] == 2'b11) begin
                        pstate <= P_DIV;
                    end
                end
                P_WORD: begin
                    shreg <= word_next;
                    if (bcnt == LAST_B) begin
                        pstate <= P_CMD;
                        unique case (addr)
                            2'd0: icx <= word_next;
                            2'd1: icy <= word_next;
                            2'd2: mu  <= word_next;
                            2'd3: dt  <= word_next;
                        endcase
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                P_DIV: begin
                    div    <= div_new;
                    pstate <= P_CMD;
                end
                default: pstate <= P_CMD;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Step counter: zero outside RUN, so the first RUN cycle pulses.
    // A divider rewrite reloads to 1 so the pulse just issued (count 0)
    // cannot repeat on the following cycle; div 0 means every cycle.
    always_ff @(posedge clk) begin
        if (rst || state != S_RUN) begin
            cnt <= '0;
        end else if (div_wr) begin
            cnt <= (div_new == '0) ? '0 : DIV_W'(1);
        end else if (cnt >= div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        dda_en     = 1'b0;
        dda_rst    = 1'b1;
        running    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_start) state_next = S_INIT;
            end
            S_INIT: begin
                dda_en     = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                dda_rst = 1'b0;
                running = 1'b1;
                dda_en  = (cnt == '0);
                if (cmd_start)     state_next = S_INIT;
                else if (cmd_stop) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
